// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback sequencer: opcodes, instruction
// classes, FSM state encoding and writeback-mux select codes.
package wb_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_JUMP,
    CLS_BRANCH,
    CLS_ILLEGAL
  } class_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

endpackage

// File: rtl/wb_sequencer_if.sv
// Instruction handshake, data-memory request and writeback control bundle.
// master = decode/memory side, slave = the sequencer.
interface wb_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [6:0] opcode;
  logic [4:0] rd;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ready;
  logic [1:0] wb_sel;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic       pc_en;
  logic       illegal;

  modport master (
    output instr_valid, opcode, rd, mem_ready,
    input  instr_ready, mem_req, mem_we, wb_sel, rf_we, rf_waddr, pc_en, illegal
  );

  modport slave (
    input  instr_valid, opcode, rd, mem_ready,
    output instr_ready, mem_req, mem_we, wb_sel, rf_we, rf_waddr, pc_en, illegal
  );
endinterface

// File: rtl/wb_class_decode.sv
// Combinational opcode classifier: instruction class plus the writeback-mux
// select that class will use.
module wb_class_decode
  import wb_pkg::*;
(
  input  logic [6:0] opcode,
  output class_e     cls,
  output logic [1:0] sel
);

  always_comb begin
    cls = CLS_ILLEGAL;
    sel = WB_ALU;
    case (opcode)
      OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC: begin
        cls = CLS_ALU;
        sel = WB_ALU;
      end
      OP_LOAD: begin
        cls = CLS_LOAD;
        sel = WB_MEM;
      end
      OP_STORE:  cls = CLS_STORE;
      OP_JAL, OP_JALR: begin
        cls = CLS_JUMP;
        sel = WB_PC;
      end
      OP_BRANCH: cls = CLS_BRANCH;
      default: begin
        cls = CLS_ILLEGAL;
        sel = WB_ALU;
      end
    endcase
  end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback-path control FSM: sequences EXEC / MEM / WB per instruction class.
// Optional memory-wait abort with sticky err is enabled by WB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for the next instruction
// EXEC   | execute cycle, class decides the next phase
// MEM    | data-memory request outstanding
// WB     | register-file write and PC advance
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
)
(
  input  logic          clk,
  input  logic          rst_n,
  wb_sequencer_if.slave bus
`ifdef WB_TIMEOUT_EN
  ,
  output logic          err
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e     state;
  class_e     cls_q;
  logic [4:0] rd_q;
  class_e     cls_dec;
  logic [1:0] sel_dec;

  logic       instr_ready_q;
  logic       mem_req_q;
  logic       mem_we_q;
  logic [1:0] wb_sel_q;
  logic       rf_we_q;
  logic [4:0] rf_waddr_q;
  logic       pc_en_q;
  logic       illegal_q;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  assign err = err_q;
`endif

  wb_class_decode u_decode (
    .opcode (bus.opcode),
    .cls    (cls_dec),
    .sel    (sel_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cls_q         <= CLS_ALU;
      rd_q          <= 5'd0;
      instr_ready_q <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      wb_sel_q      <= WB_ALU;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= 5'd0;
      pc_en_q       <= 1'b0;
      illegal_q     <= 1'b0;
`ifdef WB_TIMEOUT_EN
      wait_cnt      <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      pc_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      rf_we_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            state         <= S_EXEC;
            cls_q         <= cls_dec;
            rd_q          <= bus.rd;
            instr_ready_q <= 1'b0;
            wb_sel_q      <= sel_dec;
            // Branch/illegal retire at the end of EXEC, so their pulses land there.
            pc_en_q       <= (cls_dec == CLS_BRANCH) || (cls_dec == CLS_ILLEGAL);
            illegal_q     <= (cls_dec == CLS_ILLEGAL);
          end
        end
        S_EXEC: begin
          case (cls_q)
            CLS_LOAD, CLS_STORE: begin
              state     <= S_MEM;
              mem_req_q <= 1'b1;
              mem_we_q  <= (cls_q == CLS_STORE);
`ifdef WB_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
            end
            CLS_ALU, CLS_JUMP: begin
              state      <= S_WB;
              rf_we_q    <= (rd_q != 5'd0);
              rf_waddr_q <= rd_q;
              pc_en_q    <= 1'b1;
            end
            default: begin
              state         <= S_IDLE;
              instr_ready_q <= 1'b1;
              wb_sel_q      <= WB_ALU;
            end
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (cls_q == CLS_LOAD) begin
              state      <= S_WB;
              rf_we_q    <= (rd_q != 5'd0);
              rf_waddr_q <= rd_q;
              pc_en_q    <= 1'b1;
            end else begin
              state         <= S_IDLE;
              instr_ready_q <= 1'b1;
              wb_sel_q      <= WB_ALU;
            end
          end
`ifdef WB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state         <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            instr_ready_q <= 1'b1;
            wb_sel_q      <= WB_ALU;
            err_q         <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_WB: begin
          state         <= S_IDLE;
          instr_ready_q <= 1'b1;
          wb_sel_q      <= WB_ALU;
          rf_waddr_q    <= 5'd0;
        end
        default: begin
          state         <= S_IDLE;
          instr_ready_q <= 1'b1;
          mem_req_q     <= 1'b0;
          mem_we_q      <= 1'b0;
          wb_sel_q      <= WB_ALU;
        end
      endcase
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.wb_sel      = wb_sel_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.illegal     = illegal_q;
  // A store retires on its mem_ready cycle, so its PC pulse follows mem_ready directly.
  assign bus.pc_en       = pc_en_q |
                           ((state == S_MEM) && (cls_q == CLS_STORE) && bus.mem_ready);

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed-vector bench for wb_sequencer; timeout scenarios follow WB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_wb_sequencer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [12:0] exp_v;

  wb_sequencer_if bus();

`ifdef WB_TIMEOUT_EN
  logic err;
`endif

  wb_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_TIMEOUT_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] outs();
    return {bus.instr_ready, bus.mem_req, bus.mem_we, bus.wb_sel, bus.rf_we,
            bus.rf_waddr, bus.pc_en, bus.illegal};
  endfunction

  function automatic logic [12:0] vec(input logic rdy, input logic req, input logic we,
                                      input logic [1:0] sel, input logic rfwe,
                                      input logic [4:0] wa, input logic pc, input logic ill);
    return {rdy, req, we, sel, rfwe, wa, pc, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.instr_valid = 1'b0;
    bus.opcode = 7'd0;
    bus.rd = 5'd0;
    bus.mem_ready = 1'b0;
    #3 rst_n = 1'b0;
    tick();
    tick();
    exp_v = vec(1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected %b", outs(), exp_v);
    end
`ifdef WB_TIMEOUT_EN
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_err: got %b expected 0", err);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    bus.instr_valid = 1'b1; bus.opcode = 7'b0110011; bus.rd = 5'd5;
    #1;
    n_vec++;
    if (bus.instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL alu_accept_ready: got %b expected 1", bus.instr_ready);
    end
    tick();
    bus.instr_valid = 1'b0; bus.opcode = 7'b1111111; bus.rd = 5'd0;
    exp_v = vec(0, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL alu_exec: got %b expected %b", outs(), exp_v);
    end
    tick();
    exp_v = vec(0, 0, 0, 2'b00, 1, 5'd5, 1, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL alu_wb: got %b expected %b", outs(), exp_v);
    end
    tick();
    exp_v = vec(1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL alu_done: got %b expected %b", outs(), exp_v);
    end
  endtask

  task automatic test_load();
    bus.instr_valid = 1'b1; bus.opcode = 7'b0000011; bus.rd = 5'd7;
    tick();
    bus.instr_valid = 1'b0; bus.opcode = 7'b0110011; bus.rd = 5'd3;
    bus.mem_ready = 1'b1;
    #1;
    exp_v = vec(0, 0, 0, 2'b01, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL load_exec: got %b expected %b", outs(), exp_v);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      #1;
      exp_v = vec(0, 1, 0, 2'b01, 0, 5'd0, 0, 0);
      n_vec++;
      if (outs() !== exp_v) begin
        n_err++;
        $display("FAIL load_mem_%0d: got %b expected %b", i, outs(), exp_v);
      end
      tick();
    end
    bus.mem_ready = 1'b0;
    exp_v = vec(0, 0, 0, 2'b01, 1, 5'd7, 1, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL load_wb: got %b expected %b", outs(), exp_v);
    end
    tick();
    exp_v = vec(1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL load_done: got %b expected %b", outs(), exp_v);
    end
  endtask

  task automatic test_store_jal();
    bus.instr_valid = 1'b1; bus.opcode = 7'b0100011; bus.rd = 5'd3;
    tick();
    bus.instr_valid = 1'b0;
    exp_v = vec(0, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL store_exec: got %b expected %b", outs(), exp_v);
    end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    exp_v = vec(0, 1, 1, 2'b00, 0, 5'd0, 1, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL store_mem: got %b expected %b", outs(), exp_v);
    end
    tick();
    bus.mem_ready = 1'b0;
    bus.instr_valid = 1'b1; bus.opcode = 7'b1101111; bus.rd = 5'd1;
    #1;
    exp_v = vec(1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL store_done: got %b expected %b", outs(), exp_v);
    end
    tick();
    bus.instr_valid = 1'b0;
    exp_v = vec(0, 0, 0, 2'b10, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL jal_exec: got %b expected %b", outs(), exp_v);
    end
    tick();
    exp_v = vec(0, 0, 0, 2'b10, 1, 5'd1, 1, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL jal_wb: got %b expected %b", outs(), exp_v);
    end
    tick();
  endtask

  task automatic test_rd0_illegal_branch();
    bus.instr_valid = 1'b1; bus.opcode = 7'b0010011; bus.rd = 5'd0;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    exp_v = vec(0, 0, 0, 2'b00, 0, 5'd0, 1, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL addi_rd0_wb: got %b expected %b", outs(), exp_v);
    end
    tick();
    bus.instr_valid = 1'b1; bus.opcode = 7'b1111111; bus.rd = 5'd9;
    tick();
    bus.instr_valid = 1'b0;
    exp_v = vec(0, 0, 0, 2'b00, 0, 5'd0, 1, 1);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL illegal_exec: got %b expected %b", outs(), exp_v);
    end
    tick();
    bus.instr_valid = 1'b1; bus.opcode = 7'b1100011; bus.rd = 5'd4;
    #1;
    exp_v = vec(1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL illegal_done: got %b expected %b", outs(), exp_v);
    end
    tick();
    bus.instr_valid = 1'b0;
    exp_v = vec(0, 0, 0, 2'b00, 0, 5'd0, 1, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL branch_exec: got %b expected %b", outs(), exp_v);
    end
    tick();
    exp_v = vec(1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL branch_done: got %b expected %b", outs(), exp_v);
    end
  endtask

  task automatic test_reset_in_mem();
    bus.instr_valid = 1'b1; bus.opcode = 7'b0000011; bus.rd = 5'd9;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    n_vec++;
    if (bus.mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mem_req_before: got %b expected 1", bus.mem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    exp_v = vec(1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL rst_async_drop: got %b expected %b", outs(), exp_v);
    end
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL rst_release_idle: got %b expected %b", outs(), exp_v);
    end
  endtask

  task automatic test_mem_wait();
`ifdef WB_TIMEOUT_EN
    bus.instr_valid = 1'b1; bus.opcode = 7'b0000011; bus.rd = 5'd4;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_v = vec(0, 1, 0, 2'b01, 0, 5'd0, 0, 0);
      n_vec++;
      if (outs() !== exp_v) begin
        n_err++;
        $display("FAIL timeout_mem_%0d: got %b expected %b", i, outs(), exp_v);
      end
      tick();
    end
    exp_v = vec(1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if ({outs(), err} !== {exp_v, 1'b1}) begin
      n_err++;
      $display("FAIL timeout_abort: got %b err %b expected %b err 1", outs(), err, exp_v);
    end
    bus.instr_valid = 1'b1; bus.opcode = 7'b0110011; bus.rd = 5'd2;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    exp_v = vec(0, 0, 0, 2'b00, 1, 5'd2, 1, 0);
    n_vec++;
    if ({outs(), err} !== {exp_v, 1'b1}) begin
      n_err++;
      $display("FAIL timeout_next_add: got %b err %b expected %b err 1", outs(), err, exp_v);
    end
    tick();
`else
    bus.instr_valid = 1'b1; bus.opcode = 7'b0000011; bus.rd = 5'd6;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      exp_v = vec(0, 1, 0, 2'b01, 0, 5'd0, 0, 0);
      n_vec++;
      if (outs() !== exp_v) begin
        n_err++;
        $display("FAIL long_wait_%0d: got %b expected %b", i, outs(), exp_v);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    exp_v = vec(0, 0, 0, 2'b01, 1, 5'd6, 1, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL long_wait_wb: got %b expected %b", outs(), exp_v);
    end
    tick();
`endif
    exp_v = vec(1, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    n_vec++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL mem_wait_done: got %b expected %b", outs(), exp_v);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_alu();
    test_load();
    test_store_jal();
    test_rd0_illegal_branch();
    test_reset_in_mem();
    test_mem_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Multi-cycle control FSM for the RISC-V core's writeback path. Accepts one decoded instruction at a time, classifies it by opcode, sequences the execute, data-memory and writeback phases, and drives the writeback-select, register-file write-enable and PC-advance controls. It sits between instruction fetch/decode and the three-way writeback mux that chooses between the ALU result, data-memory result and link PC.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: memory-wait cycles before abort; only used with WB_TIMEOUT_EN.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction fields valid.
- instr_ready  out  1  sequencer can accept.
- opcode  in  7  instr[6:0].
- rd  in  5  destination register.
- mem_req  out  1  data-memory request, held until mem_ready.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req.
- mem_ready  in  1  memory completes the request this cycle.
- wb_sel  out  2  00 ALU, 01 MEM, 10 PC (link).
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  5  write address.
- pc_en  out  1  one-cycle PC advance pulse.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- err  out  1  sticky memory-timeout flag; exists only with WB_TIMEOUT_EN.

## Operation
- Classes: ALU (0110011, 0010011, 0110111, 0010111) -> wb_sel 00, write. LOAD (0000011) -> memory read, wb_sel 01, write. STORE (0100011) -> memory write, no write. JUMP (1101111, 1100111) -> wb_sel 10, write. BRANCH (1100011) -> no write. Anything else -> ILLEGAL, no write.
- Handshake: accept when instr_valid && instr_ready. opcode and rd are registered at accept and later changes on the inputs are ignored. instr_ready is 1 only in IDLE.
- States: IDLE, EXEC, MEM, WB.
  - IDLE -> EXEC on accept.
  - EXEC -> MEM for LOAD or STORE; EXEC -> WB for ALU or JUMP; EXEC -> IDLE for BRANCH or ILLEGAL. pc_en pulses on this exit. illegal pulses for ILLEGAL.
  - MEM: mem_req = 1, mem_we = 1 for STORE. On the mem_ready cycle, LOAD -> WB; STORE -> IDLE with a pc_en pulse.
  - WB: rf_we = 1 unless rd == 0. rf_waddr = latched rd. pc_en = 1. Next state is IDLE.
- wb_sel holds the latched class code from EXEC through WB and is 00 otherwise.
- mem_ready outside MEM is ignored.

## Timing
- Reset values: state IDLE, instr_ready 1, all other outputs 0 (err 0).
- All outputs are registered-state decodes with no input-to-output combinational path, except that the MEM exit is sampled from mem_ready in the same cycle.
- Cycles from accept (cycle 0, IDLE):
  - ALU/JUMP: EXEC at cycle 1, WB at cycle 2, next accept at cycle 3.
  - BRANCH/ILLEGAL: EXEC at cycle 1, next accept at cycle 2.
  - LOAD: MEM from cycle 2, held N+1 cycles when mem_ready rises N cycles late, then WB for 1 cycle.
  - STORE: same MEM timing as LOAD, with no WB.
- If mem_ready is high on the first MEM cycle, MEM lasts exactly 1 cycle.
- Reset asserted in any state immediately forces IDLE and drops mem_req, rf_we and pc_en, with no partial writeback.
- Back-to-back instructions have no bubble beyond the IDLE accept cycle.

## Configuration
- WB_TIMEOUT_EN defined:
  - A counter runs in MEM while mem_ready is low.
  - Reaching TIMEOUT_CYCLES drops mem_req, sets err, and returns to IDLE with no rf_we and no pc_en.
  - err clears only on reset.
  - The counter clears on MEM entry.
- WB_TIMEOUT_EN undefined: MEM waits indefinitely, with no counter, no err port and no TIMEOUT_CYCLES logic.

## Structure
- Package wb_pkg holds:
  - the opcode constants;
  - the class enum (ALU, LOAD, STORE, JUMP, BRANCH, ILLEGAL);
  - the state encoding;
  - the wb_sel codes WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10.
- Sub-module wb_class_decode: combinational opcode -> class + wb_sel. The FSM stays in wb_sequencer.

## Test plan
- ADD opcode 0110011, rd = 5 -> wb_sel 00 and rf_we = 1, rf_waddr = 5, pc_en = 1, all in cycle 2; instr_ready = 1 again in cycle 3.
- LW opcode 0000011, rd = 7, mem_ready raised 3 cycles after mem_req:
  - mem_req held for 4 cycles with mem_we = 0;
  - then one WB cycle with wb_sel 01, rf_we = 1, rf_waddr = 7.
- SW opcode 0100011, mem_ready high immediately -> mem_we = 1 for 1 cycle, pc_en pulses on that cycle, rf_we never asserts. Then JAL opcode 1101111, rd = 1 -> wb_sel 10, rf_we = 1, rf_waddr = 1.
- ADDI with rd = 0 -> pc_en pulses, rf_we stays 0. Opcode 1111111 -> illegal pulse in cycle 1, no rf_we, return to IDLE.
- rst_n low during MEM of a load -> mem_req = 0 asynchronously, no WB; after release, instr_ready = 1.
- With WB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_ready never high -> mem_req drops after 8 MEM cycles, err = 1 and stays set, no pc_en; the next ADD completes normally.
